// File: rtl/gpo_pulse_if.sv
// Slot bus between a register-slot master and the gpo_pulse block.
// All fields are 32-bit or narrower; the output width lives on the block itself.
interface gpo_pulse_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/gpo_pulse.sv
// General-purpose outputs with set/clear/toggle access and a timed inverting pulse.
// Define GPO_PULSE_READBACK_EN to enable register readback on rd_data.
module gpo_pulse #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    gpo_pulse_if.slave        bus,
    output logic [W-1:0]      dout
);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [15:0]   width_q, width_d;
    logic [W-1:0]  mask_q, mask_d;
    logic [15:0]   count_q, count_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          wr_en;
    logic          trigger;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        data_d  = data_q;
        width_d = width_q;
        mask_d  = mask_q;
        count_d = count_q;
        state_d = state_q;
        trigger = 1'b0;
        wr_en   = bus.cs & bus.write;

        if (wr_en) begin
            case (bus.addr)
                5'd0:    data_d  = bus.wr_data[W-1:0];
                5'd1:    data_d  = data_q | bus.wr_data[W-1:0];
                5'd2:    data_d  = data_q & ~bus.wr_data[W-1:0];
                5'd3:    data_d  = data_q ^ bus.wr_data[W-1:0];
                5'd4:    width_d = bus.wr_data[15:0];
                5'd5:    trigger = 1'b1;
                default: ;
            endcase
        end

        // A trigger (from IDLE or mid-pulse) restarts with the width latched before this write.
        if (trigger && (width_q != 16'd0)) begin
            mask_d  = bus.wr_data[W-1:0];
            count_d = width_q;
            state_d = PULSE;
        end else if (state_q == PULSE) begin
            if (count_q <= 16'd1) begin
                count_d = 16'd0;
                state_d = IDLE;
            end else begin
                count_d = count_q - 16'd1;
            end
        end

        dout_d = data_d ^ ((state_d == PULSE) ? mask_d : '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            width_q <= '0;
            mask_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            width_q <= width_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

`ifdef GPO_PULSE_READBACK_EN
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            5'd0:    rd_mux = 32'(data_q);
            5'd4:    rd_mux = 32'(width_q);
            5'd5:    rd_mux = 32'(mask_q);
            5'd6:    rd_mux = {31'b0, state_q == PULSE};
            default: rd_mux = '0;
        endcase
    end

    assign bus.rd_data = rd_mux;
`else
    assign bus.rd_data = '0;
`endif

    // Reads have no side effects and upper write-data bits may be unused for narrow W.
    logic unused_ok;
    assign unused_ok = ^{bus.read, bus.wr_data};

endmodule
